gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the combinational gate-model netlists in the gate library: 19 inputs, 10 outputs. It drives pseudo-random input vectors from a 19-bit LFSR into the netlist and waits a programmable settle time per vector. It compresses each 10-bit response into a 16-bit MISR signature and compares the final signature against a golden value. It sits between the simulator test harness and one gate-model instance.

---
 rtl/gate_bist_pkg.sv | 30 +++
 rtl/gate_bist_ctrl_if.sv | 28 ++
 rtl/gate_bist_misr.sv | 46 ++++
 rtl/gate_bist_ctrl.sv | 142 ++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST sequencer.
// Holds the FSM encoding, LFSR taps, MISR polynomial and zero-seed substitute.
package gate_bist_pkg;

  localparam int unsigned IN_W  = 19;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned SIG_W = 16;
  localparam int unsigned IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Fibonacci taps for x^19 + x^6 + x^2 + x + 1
  localparam int unsigned LFSR_TAP0 = 18;
  localparam int unsigned LFSR_TAP1 = 5;
  localparam int unsigned LFSR_TAP2 = 1;
  localparam int unsigned LFSR_TAP3 = 0;

  localparam logic [SIG_W-1:0] MISR_POLY  = 16'h1021;
  localparam logic [IN_W-1:0]  SEED_SUBST = IN_W'(1);

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
    return {v[IN_W-2:0], v[LFSR_TAP0] ^ v[LFSR_TAP1] ^ v[LFSR_TAP2] ^ v[LFSR_TAP3]};
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Harness-side bundle between the test harness, the BIST sequencer and the netlist.
// master = harness/netlist side, slave = sequencer.
interface gate_bist_ctrl_if;
  import gate_bist_pkg::*;

  logic             start;
  logic             abort;
  logic [IN_W-1:0]  seed;
  logic [SIG_W-1:0] golden_sig;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [IDX_W-1:0] pat_idx;

  modport master (
    output start, abort, seed, golden_sig, dut_out,
    input  dut_in, busy, done, pass, signature, pat_idx
  );

  modport slave (
    input  start, abort, seed, golden_sig, dut_out,
    output dut_in, busy, done, pass, signature, pat_idx
  );

endinterface

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register: shift with feedback polynomial, XOR in the response.
// sig_nxt_c exposes the value the next enabled edge would load.
module gate_bist_misr #(
  parameter int unsigned          SIG_W = 16,
  parameter int unsigned          OUT_W = 10,
  parameter logic [SIG_W-1:0]     POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt_c
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_nxt_c = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(din);
  end

  // Clear takes precedence over a capture in the same cycle
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = sig_nxt_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: LFSR vectors into a combinational netlist, settle, capture into a MISR,
// then compare the final signature with a golden value.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned PAT_CNT = 256,
  parameter int unsigned SETTLE  = 2
) (
  input logic             clk,
  input logic             rst,
  gate_bist_ctrl_if.slave bus
);

  localparam int unsigned       CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_CNT - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pat_idx_q, pat_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             misr_clr_c;
  logic             misr_en_c;
  logic [SIG_W-1:0] misr_sig;
  logic [SIG_W-1:0] misr_nxt_c;

  gate_bist_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .clr       (misr_clr_c),
    .en        (misr_en_c),
    .din       (bus.dut_out),
    .sig       (misr_sig),
    .sig_nxt_c (misr_nxt_c)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    pat_idx_d  = pat_idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    misr_clr_c = 1'b0;
    misr_en_c  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Start outranks abort when not running
        if (bus.start) begin
          lfsr_d     = (bus.seed == '0) ? SEED_SUBST : bus.seed;
          misr_clr_c = 1'b1;
          pat_idx_d  = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          misr_en_c = 1'b1;
          lfsr_d    = lfsr_step(lfsr_q);
          pat_idx_d = pat_idx_q + IDX_W'(1);
          cnt_d     = '0;
          if (pat_idx_q == IDX_LAST) begin
            // Compare against the value the MISR is loading on this edge
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_nxt_c == bus.golden_sig);
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      pat_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      pat_idx_q <= pat_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // The LFSR register itself is the netlist stimulus; it only moves on capture
  assign bus.dut_in    = lfsr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_sig;
  assign bus.pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: three instances with different run lengths,
// directed steps plus randomized seeds/netlist keys checked against a behavioural model.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] b_out;
  logic [9:0] c_key;

  gate_bist_ctrl_if ia ();
  gate_bist_ctrl_if ib ();
  gate_bist_ctrl_if ic ();

  gate_bist_ctrl #(.PAT_CNT(3), .SETTLE(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  gate_bist_ctrl #(.PAT_CNT(2), .SETTLE(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
  gate_bist_ctrl                            u_c (.clk(clk), .rst(rst), .bus(ic));

  // Behavioural stand-in for a combinational gate netlist
  function automatic logic [9:0] netlist(input logic [18:0] v, input logic [9:0] key);
    int unsigned x;
    x = (32'(v) * 32'd37) >> 4;
    return 10'(x) ^ key;
  endfunction

  assign ia.dut_out = 10'h155;
  assign ib.dut_out = b_out;
  assign ic.dut_out = netlist(ic.dut_in, c_key);

  function automatic logic [18:0] m_lfsr(input logic [18:0] v);
    logic [18:0] m;
    logic        fb;
    m  = 19'h40023;
    fb = ^(v & m);
    return {v[17:0], fb};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [9:0] d);
    int unsigned x;
    x = 32'(s) << 1;
    if ((x & 32'h10000) != 0) x = x ^ 32'h11021;
    x = x ^ 32'(d);
    return 16'(x);
  endfunction

  task automatic model_run(input logic [18:0] seed, input logic [9:0] key, input int n,
                           output logic [15:0] sig, output logic [18:0] lf);
    lf  = (seed == 19'd0) ? 19'd1 : seed;
    sig = 16'd0;
    for (int i = 0; i < n; i++) begin
      sig = m_misr(sig, netlist(lf, key));
      lf  = m_lfsr(lf);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return ia.done;
      1:       return ib.done;
      default: return ic.done;
    endcase
  endfunction

  task automatic wait_done(input string tag, input int which, input int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc = cyc + 1;
    end while (get_done(which) !== 1'b1 && cyc < budget);
    check(tag, 32'(get_done(which)), 32'd1);
  endtask

  logic [15:0] e_sig;
  logic [18:0] e_lf;
  logic [18:0] seed_r;
  int          cyc;

  initial begin
    rst = 1'b1;
    ia.start = 0; ia.abort = 0; ia.seed = '0; ia.golden_sig = '0;
    ib.start = 0; ib.abort = 0; ib.seed = '0; ib.golden_sig = '0;
    ic.start = 0; ic.abort = 0; ic.seed = '0; ic.golden_sig = '0;
    b_out = 10'h001;
    c_key = 10'($urandom);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst_busy", 32'(ic.busy), 0);
    check("rst_done", 32'(ic.done), 0);
    check("rst_pass", 32'(ic.pass), 0);
    check("rst_sig", 32'(ic.signature), 0);
    check("rst_idx", 32'(ic.pat_idx), 0);
    check("rst_dut_in", 32'(ic.dut_in), 0);

    // LFSR sequence, PAT_CNT=3 SETTLE=1
    ia.seed = 19'd1; ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    check("a_busy", 32'(ia.busy), 1);
    check("a_vec0", 32'(ia.dut_in), 32'h00001);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) check("a_vec0_hold", 32'(ia.dut_in), 32'h00001);
      if (c == 2) check("a_vec1", 32'(ia.dut_in), 32'h00003);
      if (c == 4) check("a_vec2", 32'(ia.dut_in), 32'h00006);
      if (c == 5) check("a_done_early", 32'(ia.done), 0);
    end
    check("a_done_at6", 32'(ia.done), 1);
    check("a_busy_end", 32'(ia.busy), 0);
    check("a_idx", 32'(ia.pat_idx), 3);

    // MISR accumulation with constant response, matching golden
    ib.seed = 19'($urandom); ib.golden_sig = 16'h0003; ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    wait_done("b_done1", 1, 20, cyc);
    check("b_sig1", 32'(ib.signature), 32'h0003);
    check("b_pass1", 32'(ib.pass), 1);
    check("b_idx1", 32'(ib.pat_idx), 2);

    // Same response, mismatching golden; restart from DONE
    ib.golden_sig = 16'h0004; ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    check("b_done_clr", 32'(ib.done), 0);
    wait_done("b_done2", 1, 20, cyc);
    check("b_sig2", 32'(ib.signature), 32'h0003);
    check("b_pass2", 32'(ib.pass), 0);

    // Zero seed and zero response; abort in the start cycle must lose
    b_out = 10'h000; ib.seed = 19'd0; ib.start = 1'b1; ib.abort = 1'b1;
    tick();
    ib.start = 1'b0; ib.abort = 1'b0;
    check("b_zero_busy", 32'(ib.busy), 1);
    check("b_zero_seed", 32'(ib.dut_in), 32'h00001);
    wait_done("b_done3", 1, 20, cyc);
    check("b_zero_sig", 32'(ib.signature), 0);
    check("b_zero_pass", 32'(ib.pass), 0);

    // Full-length random run with matching golden
    seed_r = 19'($urandom);
    model_run(seed_r, c_key, 256, e_sig, e_lf);
    ic.seed = seed_r; ic.golden_sig = e_sig; ic.start = 1'b1;
    tick();
    ic.start = 1'b0;
    check("c1_busy", 32'(ic.busy), 1);
    check("c1_vec0", 32'(ic.dut_in), 32'((seed_r == 19'd0) ? 19'd1 : seed_r));
    wait_done("c1_done", 2, 800, cyc);
    check("c1_latency", 32'(cyc), 768);
    check("c1_sig", 32'(ic.signature), 32'(e_sig));
    check("c1_pass", 32'(ic.pass), 1);
    check("c1_idx", 32'(ic.pat_idx), 256);
    check("c1_lfsr_end", 32'(ic.dut_in), 32'(e_lf));

    // Second random run with a corrupted golden value
    seed_r = 19'($urandom);
    model_run(seed_r, c_key, 256, e_sig, e_lf);
    ic.seed = seed_r; ic.golden_sig = e_sig ^ 16'h8000; ic.start = 1'b1;
    tick();
    ic.start = 1'b0;
    wait_done("c2_done", 2, 800, cyc);
    check("c2_sig", 32'(ic.signature), 32'(e_sig));
    check("c2_pass", 32'(ic.pass), 0);

    // Start while busy is ignored; abort after the second capture
    seed_r = 19'($urandom) | 19'h00100;
    ic.seed = seed_r; ic.start = 1'b1;
    tick();
    ic.start = 1'b0;
    repeat (3) tick();
    check("c3_idx1", 32'(ic.pat_idx), 1);
    ic.seed = ~seed_r; ic.start = 1'b1;
    tick();
    ic.start = 1'b0;
    model_run(seed_r, c_key, 1, e_sig, e_lf);
    check("c3_restart_idx", 32'(ic.pat_idx), 1);
    check("c3_restart_vec", 32'(ic.dut_in), 32'(e_lf));
    repeat (2) tick();
    check("c3_idx2", 32'(ic.pat_idx), 2);
    ic.abort = 1'b1;
    tick();
    ic.abort = 1'b0;
    model_run(seed_r, c_key, 2, e_sig, e_lf);
    check("c3_abort_busy", 32'(ic.busy), 0);
    check("c3_abort_done", 32'(ic.done), 0);
    check("c3_abort_pass", 32'(ic.pass), 0);
    check("c3_abort_idx", 32'(ic.pat_idx), 2);
    check("c3_abort_sig", 32'(ic.signature), 32'(e_sig));
    check("c3_abort_vec", 32'(ic.dut_in), 32'(e_lf));
    repeat (4) tick();
    check("c3_idle_idx", 32'(ic.pat_idx), 2);

    // Reset mid-run must clear outputs without a clock edge
    ic.seed = 19'($urandom); ic.start = 1'b1;
    tick();
    ic.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("c4_rst_busy", 32'(ic.busy), 0);
    check("c4_rst_idx", 32'(ic.pat_idx), 0);
    check("c4_rst_sig", 32'(ic.signature), 0);
    check("c4_rst_vec", 32'(ic.dut_in), 0);
    check("c4_rst_done", 32'(ic.done), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("c4_post_busy", 32'(ic.busy), 0);
    check("c4_post_idx", 32'(ic.pat_idx), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
